// File: rtl/ram64_tester.sv
// RAM64 built-in self-test master: writes SEED+addr to every word, reads back and compares.
// Optional RAM64_TESTER_INVERT_PASS_EN adds inverted-pattern write/read phases.
module ram64_tester #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      ADDR_BITS = 6,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(16'habcd)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [WIDTH-1:0]     fail_data,
    output logic [WIDTH-1:0]     mem_in,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_load,
    input  logic [WIDTH-1:0]     mem_out
);

    localparam int unsigned          DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
`ifdef RAM64_TESTER_INVERT_PASS_EN
        S_WRITE_INV,
        S_READ_INV,
`endif
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] cnt;
    logic [WIDTH-1:0]     pat_c, exp_c;
    logic                 last_c, match_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Pattern for the current address; inverted phases use the complement
    always_comb begin
        pat_c = SEED + WIDTH'(cnt);
        exp_c = pat_c;
`ifdef RAM64_TESTER_INVERT_PASS_EN
        if (state == S_WRITE_INV || state == S_READ_INV) exp_c = ~pat_c;
`endif
        last_c  = (cnt == LAST);
        match_c = (mem_out == exp_c);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: if (last_c) state_nxt = S_READ;
            S_READ: begin
                if (!match_c) state_nxt = S_DONE;
`ifdef RAM64_TESTER_INVERT_PASS_EN
                else if (last_c) state_nxt = S_WRITE_INV;
`else
                else if (last_c) state_nxt = S_DONE;
`endif
            end
`ifdef RAM64_TESTER_INVERT_PASS_EN
            S_WRITE_INV: if (last_c) state_nxt = S_READ_INV;
            S_READ_INV:  if (!match_c || last_c) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus and status outputs decoded from state so reset drops them at once
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_load = 1'b0;
        mem_addr = '0;
        mem_in   = '0;
        case (state)
`ifdef RAM64_TESTER_INVERT_PASS_EN
            S_WRITE, S_WRITE_INV: begin
`else
            S_WRITE: begin
`endif
                busy     = 1'b1;
                mem_load = 1'b1;
                mem_addr = cnt;
                mem_in   = exp_c;
            end
`ifdef RAM64_TESTER_INVERT_PASS_EN
            S_READ, S_READ_INV: begin
`else
            S_READ: begin
`endif
                busy     = 1'b1;
                mem_addr = cnt;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Address counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        pass      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
`ifdef RAM64_TESTER_INVERT_PASS_EN
                S_WRITE, S_WRITE_INV: cnt <= ADDR_BITS'(cnt + 1'b1);
                S_READ, S_READ_INV: begin
`else
                S_WRITE: cnt <= ADDR_BITS'(cnt + 1'b1);
                S_READ: begin
`endif
                    if (!match_c) begin
                        fail_addr <= cnt;
                        fail_data <= mem_out;
                    end else begin
`ifdef RAM64_TESTER_INVERT_PASS_EN
                        if (last_c && state == S_READ_INV) pass <= 1'b1;
`else
                        if (last_c) pass <= 1'b1;
`endif
                        cnt <= ADDR_BITS'(cnt + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram64_tester.sv
// Scoreboard bench for ram64_tester with a behavioural RAM64 model and fault injection.
// Expectations follow RAM64_TESTER_INVERT_PASS_EN when it is defined.
module tb_ram64_tester;

`ifdef RAM64_TESTER_INVERT_PASS_EN
    localparam int unsigned RUN_LEN = 256;
    localparam logic [15:0] W51     = 16'h53ff;
    localparam logic [15:0] W0      = 16'h5432;
    localparam logic [15:0] W2_16   = 16'hffff;
    localparam logic [15:0] W2_63   = 16'hffd0;
`else
    localparam int unsigned RUN_LEN = 128;
    localparam logic [15:0] W51     = 16'hac00;
    localparam logic [15:0] W0      = 16'habcd;
    localparam logic [15:0] W2_16   = 16'h0000;
    localparam logic [15:0] W2_63   = 16'h002f;
`endif

    typedef struct {
        int          lat;
        logic        pass;
        logic [5:0]  fa;
        logic [15:0] fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, mem_load;
    logic [5:0]  fail_addr, mem_addr;
    logic [15:0] fail_data, mem_in, mem_out;
    logic        busy2, done2, pass2, mem_load2;
    logic [5:0]  fail_addr2, mem_addr2;
    logic [15:0] fail_data2, mem_in2, mem_out2;

    logic [15:0] ram1 [64];
    logic [15:0] ram2 [64];
    int          fault_kind = 0;
    logic [5:0]  fault_addr = '0;
    logic [15:0] fault_mask = '0;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ram64_tester u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_data(fail_data), .mem_in(mem_in), .mem_addr(mem_addr),
        .mem_load(mem_load), .mem_out(mem_out)
    );

    ram64_tester #(.SEED(16'hfff0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fail_addr2), .fail_data(fail_data2), .mem_in(mem_in2), .mem_addr(mem_addr2),
        .mem_load(mem_load2), .mem_out(mem_out2)
    );

    // RAM64 models: synchronous write, combinational read with optional stuck bits
    always @(posedge clk) begin
        if (mem_load)  ram1[mem_addr]  <= mem_in;
        if (mem_load2) ram2[mem_addr2] <= mem_in2;
    end

    always_comb begin
        mem_out = ram1[mem_addr];
        if (fault_kind == 1 && mem_addr == fault_addr) mem_out = mem_out & ~fault_mask;
        if (fault_kind == 2 && mem_addr == fault_addr) mem_out = mem_out | fault_mask;
    end

    assign mem_out2 = ram2[mem_addr2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one run, push its expectation, then pop and compare when done appears
    task automatic run(input string tag, input int exp_lat, input logic exp_pass,
                       input logic [5:0] exp_fa, input logic [15:0] exp_fd,
                       input int pa, input int pb, input bit pdone);
        exp_t e;
        int   n;
        int   busy_n;
        bit   seen;
        sb.push_back('{exp_lat, exp_pass, exp_fa, exp_fd});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && n <= 400) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (n == pa || n == pb);
                @(negedge clk);
                n++;
            end
        end
        e = sb.pop_front();
        check({tag, "_timeout"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(e.lat - 1));
        check({tag, "_pass"}, 32'(pass), 32'(e.pass));
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(e.fa));
        check({tag, "_fail_data"}, 32'(fail_data), 32'(e.fd));
        start = pdone;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_idle_hold"}, 32'(busy), 32'd0);
        check({tag, "_pass_hold"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram1[i] = '0;
            ram2[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_fail_addr", 32'(fail_addr), 32'd0);
        check("rst_fail_data", 32'(fail_data), 32'd0);
        check("rst_mem_load", 32'(mem_load), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_in", 32'(mem_in), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Clean run, plus the SEED=fff0 instance running alongside
        run("clean", RUN_LEN + 1, 1'b1, 6'd0, 16'h0000, 0, 0, 1'b0);
        check("ram_w51", 32'(ram1[51]), 32'(W51));
        check("ram_w0", 32'(ram1[0]), 32'(W0));
        check("seed2_pass", 32'(pass2), 32'd1);
        check("seed2_w16", 32'(ram2[16]), 32'(W2_16));
        check("seed2_w63", 32'(ram2[63]), 32'(W2_63));

        // Stuck-at-0 bit0 at address 6 aborts READ at that address
        fault_kind = 1; fault_addr = 6'd6; fault_mask = 16'h0001;
        run("stuck0_a6", 72, 1'b0, 6'd6, 16'habd2, 0, 0, 1'b0);
        fault_kind = 0;

        // Starts mid-run and on the done cycle are ignored
        run("ignore_start", RUN_LEN + 1, 1'b1, 6'd0, 16'h0000, 10, 100, 1'b1);

        // Asynchronous reset during WRITE
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_load_pre", 32'(mem_load), 32'd1);
        check("mid_pass_pre", 32'(pass), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_load", 32'(mem_load), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run("after_reset", RUN_LEN + 1, 1'b1, 6'd0, 16'h0000, 0, 0, 1'b0);

        // Stuck-at-1 bit0 at address 0 only shows in the inverted pattern
        fault_kind = 2; fault_addr = 6'd0; fault_mask = 16'h0001;
`ifdef RAM64_TESTER_INVERT_PASS_EN
        run("stuck1_a0", 194, 1'b0, 6'd0, 16'h5433, 0, 0, 1'b0);
`else
        run("stuck1_a0", RUN_LEN + 1, 1'b1, 6'd0, 16'h0000, 0, 0, 1'b0);
`endif
        fault_kind = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ram64_tester.md
Name: ram64_tester

Overview:
- Memory-side initiator for the 64-word, 16-bit RAM64 interface: drives in/addr/load and samples the combinational out.
- On a start pulse it writes a deterministic pattern to every word, then reads each word back and compares it.
- Reports pass/fail, the first failing address and the data read there.
- Used as a built-in self-test of the registers_and_rams hierarchy and as a reusable bus master for RAM benches.

Parameters:
- WIDTH, 16, data word width; equals RAM64 word width.
- ADDR_BITS, 6, address width; depth = 2**ADDR_BITS = 64.
- SEED, 16'habcd, pattern base; word at address a = SEED + a, modulo 2**WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- busy  output  1  high while a run is in progress (WRITE/READ phases).
- done  output  1  one-cycle pulse when a run ends.
- pass  output  1  result of the last completed run; 1 = no mismatch.
- fail_addr  output  ADDR_BITS  address of the first mismatch; 0 if none.
- fail_data  output  WIDTH  mem_out value captured at the first mismatch; 0 if none.
- mem_in  output  WIDTH  write data to RAM in.
- mem_addr  output  ADDR_BITS  address to RAM addr.
- mem_load  output  1  write enable to RAM load.
- mem_out  input  WIDTH  RAM out, combinational read of mem_addr.

Behaviour:
- Clock is one clock, clk. Reset is asynchronous and active-high, named reset.
- State machine states: IDLE, WRITE, READ, DONE. A counter cnt is ADDR_BITS wide.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, cnt=0.
  - busy=0, done=0, pass=0, fail_addr=0, fail_data=0.
  - mem_load=0, mem_addr=0, mem_in=0.
- mem_load is decoded from state, not registered. Asserting reset during WRITE drops mem_load in the same instant. RAM contents are left partially written, with no rollback.
- IDLE:
  - All mem_* outputs are 0.
  - When start=1 at a rising edge: go to WRITE, cnt=0, pass=0, fail_addr=0, fail_data=0.
  - When start=0: stay in IDLE.
- WRITE:
  - Outputs: mem_load=1, mem_addr=cnt, mem_in=SEED+cnt (truncated to WIDTH).
  - The RAM captures the word at each edge.
  - If cnt==63: go to READ, cnt=0. Otherwise cnt increments.
  - Takes exactly 64 cycles.
- READ:
  - Outputs: mem_load=0, mem_addr=cnt.
  - Expected value exp=SEED+cnt. mem_out is compared to exp at the edge that ends the cycle.
  - On mismatch: fail_addr=cnt, fail_data=mem_out, pass stays 0, go to DONE immediately (early abort).
  - On match with cnt==63: pass=1, go to DONE.
  - Otherwise cnt increments.
- DONE:
  - done=1 for exactly one cycle, busy=0, mem_load=0.
  - Always returns to IDLE. start is ignored during this cycle.
- busy is 1 in WRITE and READ, 0 in IDLE and DONE.
- Timing: start is accepted at edge E0. busy is high for 128 cycles on a clean run. done is high in cycle 129 after E0.
- start in any state other than IDLE is ignored. There is no queueing.
- pass, fail_addr and fail_data hold their values until the next accepted start or reset.
- Pattern arithmetic wraps modulo 2**WIDTH, e.g. SEED=16'hfff0 gives address 16 = 16'h0000.

Optional Feature:
- Macro: RAM64_TESTER_INVERT_PASS_EN
- Defined:
  - After READ passes, two extra phases run: WRITE_INV, then READ_INV.
  - Both use the pattern ~(SEED+cnt) with the same rules as WRITE/READ, including early abort.
  - A clean run is 256 busy cycles. pass=1 only if all four phases pass.
  - This exercises every bit at both polarities.
- Undefined:
  - Only WRITE and READ exist. The inverted states and their logic are not compiled.

Test Plan:
1. Reset, then pulse start against a clean RAM64 model:
   - busy=1 for 128 cycles, done pulses at cycle 129.
   - pass=1, fail_addr=0, fail_data=0.
   - RAM word 51 = 16'hac00.
2. RAM model with bit0 stuck-at-0 at address 6:
   - fail_addr=6, fail_data=16'habd2, pass=0.
   - done pulses 64+7+1=72 cycles after start.
3. Pulse start again at cycles 10 and 100 of an active run:
   - Both pulses are ignored; a single done at cycle 129.
   - A start coinciding with the done cycle is also ignored.
4. Assert reset at WRITE cycle 20:
   - mem_load=0, busy=0, pass=0 immediately, before the next edge.
   - A new start then completes a full 128-cycle run with pass=1.
5. Override SEED=16'hfff0:
   - address 16 is written 16'h0000, address 63 is written 16'h002f.
   - Read-back gives pass=1.
6. With RAM64_TESTER_INVERT_PASS_EN defined:
   - done at cycle 257, pass=1, final RAM word 0 = 16'h5432.
   - A stuck-at-1 bit0 at address 0 gives fail_addr=0, fail_data=16'h5433 during READ_INV.
